// File: rtl/mpe_mul_scheduler_if.sv
// Requester and result channels of the multiplier scheduler.
// The slave modport is the scheduler's view. The master modport is the view of the lane control and the result consumer.
interface mpe_mul_scheduler_if #(
    parameter int TAG_W = 4
);
    logic             s0_valid;
    logic             s0_ready;
    logic [11:0]      s0_a;
    logic [11:0]      s0_c;
    logic [TAG_W-1:0] s0_tag;

    logic             s1_valid;
    logic             s1_ready;
    logic [11:0]      s1_a;
    logic [11:0]      s1_b;
    logic [11:0]      s1_c;
    logic [TAG_W-1:0] s1_tag;

    logic             m_valid;
    logic             m_ready;
    logic [23:0]      m_product;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;

    modport slave (
        input  s0_valid, s0_a, s0_c, s0_tag,
        output s0_ready,
        input  s1_valid, s1_a, s1_b, s1_c, s1_tag,
        output s1_ready,
        output m_valid, m_product, m_src, m_tag,
        input  m_ready
    );

    modport master (
        output s0_valid, s0_a, s0_c, s0_tag,
        input  s0_ready,
        output s1_valid, s1_a, s1_b, s1_c, s1_tag,
        input  s1_ready,
        input  m_valid, m_product, m_src, m_tag,
        output m_ready
    );
endinterface

// File: rtl/mpe_mul_scheduler.sv
// Round-robin scheduler that shares one multi-precision multiplier between a 12bX12b requester and a dual 12bX5b requester.
// It has a registered operand stage (X), a registered result stage (M), and saturating per-requester op counters.
module mpe_mul_scheduler #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mpe_mul_scheduler_if.slave   bus,
    output logic [11:0]          mul_a,
    output logic [11:0]          mul_b,
    output logic [11:0]          mul_c,
    output logic                 mul_mode,
    input  logic [23:0]          mul_product,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);
    logic             x_valid;
    logic             x_src;
    logic [TAG_W-1:0] x_tag;
    logic             rr_s1_last;
    logic             out_free, x_adv, accept_ok;
    logic             grant0, grant1, acc0, acc1, accept;

    assign out_free  = ~bus.m_valid | bus.m_ready;
    assign x_adv     = x_valid & out_free;
    assign accept_ok = ~x_valid | x_adv;

    // When both requesters are valid, the grant goes to the one that did not win the last accepted handshake.
    assign grant0 = bus.s0_valid & (~bus.s1_valid | rr_s1_last);
    assign grant1 = bus.s1_valid & (~bus.s0_valid | ~rr_s1_last);

    assign bus.s0_ready = accept_ok & grant0;
    assign bus.s1_ready = accept_ok & grant1;
    assign acc0   = bus.s0_valid & bus.s0_ready;
    assign acc1   = bus.s1_valid & bus.s1_ready;
    assign accept = acc0 | acc1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_c      <= '0;
            mul_mode   <= 1'b0;
            x_valid    <= 1'b0;
            x_src      <= 1'b0;
            x_tag      <= '0;
            rr_s1_last <= 1'b1;
        end else begin
            if (acc0) begin
                mul_a    <= bus.s0_a;
                mul_b    <= '0;
                mul_c    <= bus.s0_c;
                mul_mode <= 1'b0;
                x_src    <= 1'b0;
                x_tag    <= bus.s0_tag;
            end else if (acc1) begin
                mul_a    <= bus.s1_a;
                mul_b    <= bus.s1_b;
                mul_c    <= bus.s1_c;
                mul_mode <= 1'b1;
                x_src    <= 1'b1;
                x_tag    <= bus.s1_tag;
            end
            x_valid <= accept | (x_valid & ~x_adv);
            if (accept)
                rr_s1_last <= acc1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid   <= 1'b0;
            bus.m_product <= '0;
            bus.m_src     <= 1'b0;
            bus.m_tag     <= '0;
        end else if (x_adv) begin
            bus.m_valid   <= 1'b1;
            bus.m_product <= mul_product;
            bus.m_src     <= x_src;
            bus.m_tag     <= x_tag;
        end else if (bus.m_ready) begin
            bus.m_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0 && cnt0 != '1)
                cnt0 <= cnt0 + 1'b1;
            if (acc1 && cnt1 != '1)
                cnt1 <= cnt1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_mpe_mul_scheduler.sv
// Scoreboard bench for mpe_mul_scheduler: stimulus pushes expected results and a monitor pops them as results transfer.
// An environment multiplier model drives mul_product from the registered operands.
module tb_mpe_mul_scheduler;
    typedef struct packed {
        logic        src;
        logic [3:0]  tag;
        logic [23:0] prod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] mul_a, mul_b, mul_c;
    logic        mul_mode;
    logic [23:0] mul_product;
    logic        cnt_clr;
    logic [2:0]  cnt0, cnt1;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    mpe_mul_scheduler_if #(.TAG_W(4)) bus ();

    mpe_mul_scheduler #(.TAG_W(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_c       (mul_c),
        .mul_mode    (mul_mode),
        .mul_product (mul_product),
        .cnt_clr     (cnt_clr),
        .cnt0        (cnt0),
        .cnt1        (cnt1)
    );

    always #5 clk = ~clk;

    // Mode 1 model: the low half is a*c[4:0] and the high half is b*c[9:5], each truncated to 12 bits.
    always_comb begin
        logic [16:0] lo, hi;
        lo = mul_a * mul_c[4:0];
        hi = mul_b * mul_c[9:5];
        if (mul_mode)
            mul_product = {hi[11:0], lo[11:0]};
        else
            mul_product = mul_a * mul_c;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic [3:0] tag, input logic [23:0] prod);
        exp_t e;
        e.src  = src;
        e.tag  = tag;
        e.prod = prod;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result got src=%0d tag=%0d prod=0x%0h expected=none",
                         bus.m_src, bus.m_tag, bus.m_product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.m_src, bus.m_tag, bus.m_product} !== e) begin
                    n_fail++;
                    $display("FAIL result got src=%0d tag=%0d prod=0x%0h expected src=%0d tag=%0d prod=0x%0h",
                             bus.m_src, bus.m_tag, bus.m_product, e.src, e.tag, e.prod);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus.s0_valid = 1'b0; bus.s0_a = '0; bus.s0_c = '0; bus.s0_tag = '0;
        bus.s1_valid = 1'b0; bus.s1_a = '0; bus.s1_b = '0; bus.s1_c = '0; bus.s1_tag = '0;
        bus.m_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_mul_mode", {31'd0, mul_mode}, 32'd0);
        chk("rst_cnt0", {29'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {29'd0, cnt1}, 32'd0);
        chk("rst_s0_ready_idle", {31'd0, bus.s0_ready}, 32'd0);
        step();

        // s0 only
        bus.m_ready = 1'b1;
        bus.s0_valid = 1'b1; bus.s0_a = 12'd100; bus.s0_c = 12'd200; bus.s0_tag = 4'd3;
        @(negedge clk);
        chk("t1_s0_ready", {31'd0, bus.s0_ready}, 32'd1);
        chk("t1_s1_ready", {31'd0, bus.s1_ready}, 32'd0);
        push(1'b0, 4'd3, 24'd20000);
        step();
        bus.s0_valid = 1'b0;
        @(negedge clk);
        chk("t1_mul_mode", {31'd0, mul_mode}, 32'd0);
        chk("t1_mul_b", {20'd0, mul_b}, 32'd0);
        chk("t1_mul_a", {20'd0, mul_a}, 32'd100);
        chk("t1_latency_m_valid", {31'd0, bus.m_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("t1_cnt0", {29'd0, cnt0}, 32'd1);
        step();

        // s1 only
        bus.s1_valid = 1'b1; bus.s1_a = 12'd7; bus.s1_b = 12'd9; bus.s1_c = 12'h0A5; bus.s1_tag = 4'd5;
        @(negedge clk);
        chk("t2_s1_ready", {31'd0, bus.s1_ready}, 32'd1);
        chk("t2_s0_ready", {31'd0, bus.s0_ready}, 32'd0);
        push(1'b1, 4'd5, 24'h02D023);
        step();
        bus.s1_valid = 1'b0;
        @(negedge clk);
        chk("t2_mul_mode", {31'd0, mul_mode}, 32'd1);
        chk("t2_mul_b", {20'd0, mul_b}, 32'd9);
        step(); step();

        // both valid for 6 cycles
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.s0_valid = 1'b1; bus.s0_a = 12'(i + 1); bus.s0_c = 12'd10; bus.s0_tag = 4'(i);
            bus.s1_valid = 1'b1; bus.s1_a = 12'(i + 2); bus.s1_b = 12'd3; bus.s1_c = 12'h021;
            bus.s1_tag = 4'(i + 8);
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("t3_grant_s0", {30'd0, bus.s0_ready, bus.s1_ready}, 32'd2);
                push(1'b0, 4'(i), 24'((i + 1) * 10));
            end else begin
                chk("t3_grant_s1", {30'd0, bus.s0_ready, bus.s1_ready}, 32'd1);
                push(1'b1, 4'(i + 8), {12'd3, 12'(i + 2)});
            end
            step();
        end
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        @(negedge clk);
        chk("t3_cnt0", {29'd0, cnt0}, 32'd3);
        chk("t3_cnt1", {29'd0, cnt1}, 32'd3);
        step(); step(); step();

        // backpressure: two ops are held in X and M and the third op is refused
        bus.m_ready = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_a = 12'd11; bus.s0_c = 12'd13; bus.s0_tag = 4'd1;
        @(negedge clk);
        chk("t4_ready_a", {31'd0, bus.s0_ready}, 32'd1);
        push(1'b0, 4'd1, 24'd143);
        step();
        bus.s0_a = 12'd17; bus.s0_c = 12'd19; bus.s0_tag = 4'd2;
        @(negedge clk);
        chk("t4_ready_b", {31'd0, bus.s0_ready}, 32'd1);
        push(1'b0, 4'd2, 24'd323);
        step();
        bus.s0_a = 12'd23; bus.s0_c = 12'd29; bus.s0_tag = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready_c_stalled", {31'd0, bus.s0_ready}, 32'd0);
            chk("t4_m_valid_held", {31'd0, bus.m_valid}, 32'd1);
            chk("t4_m_product_held", {8'd0, bus.m_product}, 32'd143);
            chk("t4_mul_a_held", {20'd0, mul_a}, 32'd17);
            step();
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_c_released", {31'd0, bus.s0_ready}, 32'd1);
        push(1'b0, 4'd3, 24'd667);
        step();
        bus.s0_valid = 1'b0;
        repeat (4) step();

        // counter saturation and clear priority
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.s0_valid = 1'b1; bus.s0_a = 12'(i + 1); bus.s0_c = 12'd2; bus.s0_tag = 4'(i);
            @(negedge clk);
            chk("t5_ready_stream", {31'd0, bus.s0_ready}, 32'd1);
            push(1'b0, 4'(i), 24'((i + 1) * 2));
            step();
        end
        bus.s0_valid = 1'b0;
        @(negedge clk);
        chk("t5_cnt0_saturated", {29'd0, cnt0}, 32'd7);
        step();
        bus.s0_valid = 1'b1; bus.s0_a = 12'd50; bus.s0_c = 12'd3; bus.s0_tag = 4'd9;
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("t5_ready_clr", {31'd0, bus.s0_ready}, 32'd1);
        push(1'b0, 4'd9, 24'd150);
        step();
        bus.s0_valid = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("t5_cnt0_clr_wins", {29'd0, cnt0}, 32'd0);
        step(); step(); step();

        // reset asserted while X and M are both full
        bus.m_ready = 1'b0;
        bus.s0_valid = 1'b1; bus.s0_a = 12'd1; bus.s0_c = 12'd1; bus.s0_tag = 4'd0;
        step();
        bus.s0_a = 12'd2; bus.s0_c = 12'd2;
        step();
        bus.s0_valid = 1'b0;
        @(negedge clk);
        chk("t6_m_valid_before_rst", {31'd0, bus.m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid_async_drop", {31'd0, bus.m_valid}, 32'd0);
        chk("t6_m_product_cleared", {8'd0, bus.m_product}, 32'd0);
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_stale", {31'd0, bus.m_valid}, 32'd0);
            step();
        end
        bus.s0_valid = 1'b1; bus.s0_a = 12'd5; bus.s0_c = 12'd6; bus.s0_tag = 4'd7;
        bus.s1_valid = 1'b1; bus.s1_a = 12'd2; bus.s1_b = 12'd4; bus.s1_c = 12'h043; bus.s1_tag = 4'd8;
        @(negedge clk);
        chk("t6_first_grant_s0", {30'd0, bus.s0_ready, bus.s1_ready}, 32'd2);
        push(1'b0, 4'd7, 24'd30);
        step();
        @(negedge clk);
        chk("t6_second_grant_s1", {30'd0, bus.s0_ready, bus.s1_ready}, 32'd1);
        push(1'b1, 4'd8, 24'h008006);
        step();
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t6_cnt1_after_rst", {29'd0, cnt1}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
